// File: rtl/ahb_lite_master_engine.sv
// AHB-Lite single-master engine: valid/ready commands to pipelined SINGLE transfers.
// Optional AHB_MASTER_ALIGN_CHECK_EN rejects misaligned or oversized commands locally.
module ahb_lite_master_engine #(
    parameter int ADDRWIDTH = 32,
    parameter int DATAWIDTH = 32
) (
    input  logic                 HCLK,
    input  logic                 HRESETn,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_write,
    input  logic [ADDRWIDTH-1:0] cmd_addr,
    input  logic [2:0]           cmd_size,
    input  logic [DATAWIDTH-1:0] cmd_wdata,
    output logic                 rsp_valid,
    output logic                 rsp_write,
    output logic                 rsp_error,
    output logic [DATAWIDTH-1:0] rsp_rdata,
    output logic [ADDRWIDTH-1:0] HADDR,
    output logic                 HWRITE,
    output logic [2:0]           HSIZE,
    output logic [2:0]           HBURST,
    output logic [3:0]           HPROT,
    output logic                 HMASTLOCK,
    output logic [1:0]           HTRANS,
    output logic [DATAWIDTH-1:0] HWDATA,
    input  logic [DATAWIDTH-1:0] HRDATA,
    input  logic                 HREADY,
    input  logic                 HRESP
);

    localparam logic [0:0] RUN  = 1'b0;
    localparam logic [0:0] ERR2 = 1'b1;

    logic [0:0]           state_q, state_d;
    logic                 a_vld_q, a_vld_d;
    logic                 a_wr_q, a_wr_d;
    logic [ADDRWIDTH-1:0] a_addr_q, a_addr_d;
    logic [2:0]           a_size_q, a_size_d;
    logic [DATAWIDTH-1:0] a_wdata_q, a_wdata_d;
    logic                 a_lerr_q, a_lerr_d;
    logic                 d_vld_q, d_vld_d;
    logic                 d_wr_q, d_wr_d;
    logic [DATAWIDTH-1:0] d_wdata_q, d_wdata_d;
    logic                 d_lerr_q, d_lerr_d;
    logic                 rsp_vld_q, rsp_vld_d;
    logic                 rsp_wr_q, rsp_wr_d;
    logic                 rsp_err_q, rsp_err_d;
    logic [DATAWIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                 accept;
    logic                 cmd_lerr;

`ifdef AHB_MASTER_ALIGN_CHECK_EN
    logic [7:0] size_mask;
    logic       misalign;
    logic       too_wide;
    assign size_mask = 8'((9'd1 << cmd_size) - 9'd1);
    assign misalign  = |(cmd_addr[7:0] & size_mask);
    assign too_wide  = (32'd8 << cmd_size) > 32'(DATAWIDTH);
    assign cmd_lerr  = misalign | too_wide;
`else
    assign cmd_lerr  = 1'b0;
`endif

    assign cmd_ready = HRESETn && HREADY && (state_q == RUN);
    assign accept    = cmd_valid && cmd_ready;

    always_comb begin
        state_d   = state_q;
        a_vld_d   = a_vld_q;
        a_wr_d    = a_wr_q;
        a_addr_d  = a_addr_q;
        a_size_d  = a_size_q;
        a_wdata_d = a_wdata_q;
        a_lerr_d  = a_lerr_q;
        d_vld_d   = d_vld_q;
        d_wr_d    = d_wr_q;
        d_wdata_d = d_wdata_q;
        d_lerr_d  = d_lerr_q;
        if (state_q == RUN) begin
            if (HREADY) begin
                d_vld_d  = a_vld_q;
                d_wr_d   = a_wr_q;
                d_lerr_d = a_lerr_q;
                if (a_vld_q) d_wdata_d = a_wdata_q;
                a_vld_d = accept;
                if (accept) begin
                    a_wr_d    = cmd_write;
                    a_addr_d  = cmd_addr;
                    a_size_d  = cmd_size;
                    a_wdata_d = cmd_wdata;
                    a_lerr_d  = cmd_lerr;
                end
            end else if (d_vld_q && HRESP && !d_lerr_q) begin
                state_d = ERR2;
            end
        end else if (HREADY) begin
            // Second ERROR cycle ends the data phase; A stays put for reissue.
            state_d = RUN;
            d_vld_d = 1'b0;
        end
    end

    always_comb begin
        rsp_vld_d   = 1'b0;
        rsp_wr_d    = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;
        if (d_vld_q && HREADY) begin
            rsp_vld_d = 1'b1;
            rsp_wr_d  = d_wr_q;
            rsp_err_d = HRESP | d_lerr_q;
            if (!d_wr_q && !HRESP && !d_lerr_q) rsp_rdata_d = HRDATA;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q     <= RUN;
            a_vld_q     <= 1'b0;
            a_wr_q      <= 1'b0;
            a_addr_q    <= '0;
            a_size_q    <= '0;
            a_wdata_q   <= '0;
            a_lerr_q    <= 1'b0;
            d_vld_q     <= 1'b0;
            d_wr_q      <= 1'b0;
            d_wdata_q   <= '0;
            d_lerr_q    <= 1'b0;
            rsp_vld_q   <= 1'b0;
            rsp_wr_q    <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            a_vld_q     <= a_vld_d;
            a_wr_q      <= a_wr_d;
            a_addr_q    <= a_addr_d;
            a_size_q    <= a_size_d;
            a_wdata_q   <= a_wdata_d;
            a_lerr_q    <= a_lerr_d;
            d_vld_q     <= d_vld_d;
            d_wr_q      <= d_wr_d;
            d_wdata_q   <= d_wdata_d;
            d_lerr_q    <= d_lerr_d;
            rsp_vld_q   <= rsp_vld_d;
            rsp_wr_q    <= rsp_wr_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign HTRANS    = (a_vld_q && !a_lerr_q && state_q == RUN) ? 2'b10 : 2'b00;
    assign HADDR     = a_addr_q;
    assign HWRITE    = a_wr_q;
    assign HSIZE     = a_size_q;
    assign HWDATA    = d_wdata_q;
    assign HBURST    = 3'b000;
    assign HPROT     = 4'b0011;
    assign HMASTLOCK = 1'b0;

    assign rsp_valid = rsp_vld_q;
    assign rsp_write = rsp_wr_q;
    assign rsp_error = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_ahb_lite_master_engine.sv
// Bench for ahb_lite_master_engine: scoreboard of expected responses plus a
// small wait-state / ERROR capable slave.
module tb_ahb_lite_master_engine;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [2:0]  cmd_size;
    logic        rsp_valid, rsp_write, rsp_error;
    logic [31:0] rsp_rdata;
    logic [31:0] HADDR, HWDATA, HRDATA;
    logic        HWRITE, HMASTLOCK, HREADY, HRESP;
    logic [2:0]  HSIZE, HBURST;
    logic [3:0]  HPROT;
    logic [1:0]  HTRANS;

    ahb_lite_master_engine #(.ADDRWIDTH(32), .DATAWIDTH(32)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr),
        .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_write(rsp_write),
        .rsp_error(rsp_error), .rsp_rdata(rsp_rdata),
        .HADDR(HADDR), .HWRITE(HWRITE), .HSIZE(HSIZE),
        .HBURST(HBURST), .HPROT(HPROT), .HMASTLOCK(HMASTLOCK),
        .HTRANS(HTRANS), .HWDATA(HWDATA), .HRDATA(HRDATA),
        .HREADY(HREADY), .HRESP(HRESP)
    );

    always #5 HCLK = ~HCLK;

    int nchk = 0;
    int nfail = 0;
    int cyc = 0;
    int rsp_seen = 0;
    int wait_cfg = 0;

    always @(posedge HCLK) cyc <= cyc + 1;

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    // Slave: one wait counter per data phase; addresses >= 0x100 answer ERROR
    logic [31:0] mem [16];
    logic        dp_vld_q, dp_wr_q, dp_err_q;
    logic [31:0] dp_addr_q;
    int          cnt_q;

    always @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dp_vld_q  <= 1'b0;
            dp_wr_q   <= 1'b0;
            dp_err_q  <= 1'b0;
            dp_addr_q <= '0;
            cnt_q     <= 0;
        end else begin
            if (dp_vld_q && dp_wr_q && HREADY && !HRESP)
                mem[dp_addr_q[5:2]] <= HWDATA;
            if (HREADY) begin
                dp_vld_q  <= (HTRANS == 2'b10);
                dp_wr_q   <= HWRITE;
                dp_addr_q <= HADDR;
                dp_err_q  <= (HADDR >= 32'h100);
                cnt_q     <= (HADDR >= 32'h100) ? 1 : wait_cfg;
            end else begin
                cnt_q <= cnt_q - 1;
            end
        end
    end

    always_comb begin
        HREADY = 1'b1;
        HRESP  = 1'b0;
        HRDATA = '0;
        if (dp_vld_q) begin
            HREADY = (cnt_q == 0);
            HRESP  = dp_err_q;
            if (!dp_wr_q && !dp_err_q) HRDATA = mem[dp_addr_q[5:2]];
        end
    end

    typedef struct packed {
        logic        w;
        logic        e;
        logic [31:0] d;
        logic [31:0] acc;
        logic [31:0] lat;
    } exp_t;

    exp_t sb[$];

    always @(negedge HCLK) begin
        if (HRESETn && rsp_valid) begin
            exp_t e;
            rsp_seen++;
            if (sb.size() == 0) begin
                nchk++;
                nfail++;
                $display("FAIL unexpected_rsp: got rsp_valid=1 expected none (cycle %0d)", cyc);
            end else begin
                e = sb.pop_front();
                chk("rsp_write", rsp_write, e.w);
                chk("rsp_error", rsp_error, e.e);
                chk("rsp_rdata", rsp_rdata, e.d);
                chk("rsp_latency", 32'(cyc) - e.acc, e.lat);
            end
        end
    end

    task automatic send(input logic wr, input logic [31:0] a, input logic [2:0] sz,
                        input logic [31:0] wd, input logic [1:0] xtr,
                        input logic ew, input logic ee, input logic [31:0] ed,
                        input int lat);
        int n;
        exp_t e;
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_size  = sz;
        cmd_wdata = wd;
        n = 0;
        while (!cmd_ready && n < 50) begin
            @(posedge HCLK);
            #1;
            n++;
        end
        if (n >= 50) begin
            chk("accept_timeout", 1'b0, 1'b1);
            cmd_valid = 1'b0;
            return;
        end
        @(posedge HCLK);
        #1;
        cmd_valid = 1'b0;
        e.w = ew;
        e.e = ee;
        e.d = ed;
        e.acc = 32'(cyc);
        e.lat = 32'(lat);
        sb.push_back(e);
        chk("htrans_issue", HTRANS, xtr);
        if (xtr == 2'b10) chk("haddr_issue", HADDR, a);
    endtask

    initial begin
        int stalls;
        int seen0;
        HRESETn   = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_size  = '0;
        cmd_wdata = '0;
        #1;
        chk("rst_htrans", HTRANS, 2'b00);
        chk("rst_hprot", HPROT, 4'b0011);
        chk("rst_cmd_ready", cmd_ready, 1'b0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        repeat (3) @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
        @(posedge HCLK);
        #1;
        chk("idle_cmd_ready", cmd_ready, 1'b1);

        // back-to-back writes, zero wait states
        for (int i = 0; i < 4; i++)
            send(1'b1, 32'(i * 4), 3'd2, 32'hA0 + 32'(i), 2'b10, 1'b1, 1'b0, 32'h0, 2);
        repeat (4) @(posedge HCLK);
        #1;

        // read with three wait states
        wait_cfg = 3;
        send(1'b0, 32'h04, 3'd2, 32'h0, 2'b10, 1'b0, 1'b0, 32'hA1, 5);
        stalls = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge HCLK);
            #1;
            wait_cfg = 0;
            if (!cmd_ready) begin
                stalls++;
                chk("stall_haddr", HADDR, 32'h04);
            end
        end
        chk("stall_cycles", 32'(stalls), 32'd3);

        // ERROR on a write with a read queued in A
        send(1'b1, 32'h200, 3'd2, 32'hDEAD, 2'b10, 1'b1, 1'b1, 32'h0, 3);
        send(1'b0, 32'h08, 3'd2, 32'h0, 2'b10, 1'b0, 1'b0, 32'hA2, 4);
        @(posedge HCLK);
        #1;
        chk("err2_htrans", HTRANS, 2'b00);
        @(posedge HCLK);
        #1;
        chk("reissue_htrans", HTRANS, 2'b10);
        chk("reissue_haddr", HADDR, 32'h08);
        repeat (4) @(posedge HCLK);
        #1;

        // reset in the middle of a stalled read data phase
        seen0 = rsp_seen;
        wait_cfg = 5;
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 32'h0C;
        cmd_size  = 3'd2;
        @(posedge HCLK);
        #1;
        cmd_valid = 1'b0;
        @(posedge HCLK);
        #1;
        wait_cfg = 0;
        @(posedge HCLK);
        #1;
        HRESETn = 1'b0;
        #1;
        chk("mid_rst_htrans", HTRANS, 2'b00);
        chk("mid_rst_haddr", HADDR, 32'h0);
        chk("mid_rst_hwrite", HWRITE, 1'b0);
        chk("mid_rst_cmd_ready", cmd_ready, 1'b0);
        chk("mid_rst_rsp_valid", rsp_valid, 1'b0);
        repeat (2) @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
        repeat (6) @(posedge HCLK);
        #1;
        chk("dropped_rsp_count", 32'(rsp_seen - seen0), 32'd0);
        send(1'b1, 32'h00, 3'd2, 32'h55, 2'b10, 1'b1, 1'b0, 32'h0, 2);
        send(1'b0, 32'h00, 3'd2, 32'h0, 2'b10, 1'b0, 1'b0, 32'h55, 2);
        repeat (4) @(posedge HCLK);
        #1;

`ifdef AHB_MASTER_ALIGN_CHECK_EN
        send(1'b0, 32'h06, 3'd2, 32'h0, 2'b00, 1'b0, 1'b1, 32'h0, 2);
        send(1'b1, 32'h08, 3'd2, 32'h77, 2'b10, 1'b1, 1'b0, 32'h0, 2);
        send(1'b0, 32'h00, 3'd3, 32'h0, 2'b00, 1'b0, 1'b1, 32'h0, 2);
`else
        send(1'b0, 32'h06, 3'd2, 32'h0, 2'b10, 1'b0, 1'b0, 32'hA1, 2);
`endif

        repeat (8) @(posedge HCLK);
        #1;
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
